// File: rtl/im_access_arbiter.sv
// im_access_arbiter: shares the single IM read port between fetch and a debug reader.
// Fetch has priority. A starvation counter lets a waiting debug request take the port.
// Byte addresses are translated to word indices. Misaligned or out-of-range accesses
// are granted, but they do not touch the memory and their response carries an error.
// Read data returns one cycle after the grant, to the requester that owned that cycle.
// Optional feature: define IM_ARB_STATS_EN to build the grant/stall statistics counters.
// Without it the stat_* ports read zero.
module im_access_arbiter #(
  parameter logic [31:0] INIT_ADDR  = 32'h0000_3000,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [31:0]           f_addr,
  input  logic                  f_flush,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [31:0]           f_rdata,
  output logic                  f_err,
  input  logic                  d_req,
  input  logic [31:0]           d_addr,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  output logic                  im_en,
  output logic [DEPTH_LOG2-1:0] im_addr,
  input  logic [31:0]           im_rdata,
  output logic [31:0]           stat_f_cnt,
  output logic [31:0]           stat_d_cnt,
  output logic [31:0]           stat_stall_cnt
);

  localparam int unsigned      CNT_W       = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM  = CNT_W'(STARVE_MAX);
  localparam logic [32:0]      DEPTH_WORDS = 33'(1) << DEPTH_LOG2;

  logic [CNT_W-1:0]      starve_cnt;
  logic [CNT_W-1:0]      starve_cnt_nxt;
  logic                  starve_c;
  logic                  f_gnt_c;
  logic                  d_gnt_c;
  logic [31:0]           win_addr_c;
  logic [29:0]           win_word_c;
  logic                  win_err_c;
  logic                  im_en_c;
  logic [DEPTH_LOG2-1:0] im_addr_c;

  logic f_rvalid_q;
  logic f_err_q;
  logic d_rvalid_q;
  logic d_err_q;

  // Grant decision, address translation/check and starvation counter next value
  always_comb begin
    starve_c       = (starve_cnt == STARVE_LIM);
    d_gnt_c        = 1'b0;
    f_gnt_c        = 1'b0;
    starve_cnt_nxt = starve_cnt;

    if (reset) begin
      d_gnt_c = d_req & (~f_req | starve_c);
      f_gnt_c = f_req & ~d_gnt_c;
    end

    win_addr_c = d_gnt_c ? d_addr : f_addr;
    win_word_c = 30'((win_addr_c - INIT_ADDR) >> 2);
    win_err_c  = (win_addr_c[1:0] != 2'b00) ||
                 (win_addr_c < INIT_ADDR) ||
                 ({3'b000, win_word_c} >= DEPTH_WORDS);

    im_en_c   = (f_gnt_c | d_gnt_c) & ~win_err_c;
    im_addr_c = im_en_c ? win_word_c[DEPTH_LOG2-1:0] : '0;

    if (!d_req || d_gnt_c) begin
      starve_cnt_nxt = '0;
    end else if (!starve_c) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // Starvation counter and one-deep response tracking for the issuing cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      f_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      f_rvalid_q <= f_gnt_c;
      f_err_q    <= f_gnt_c & win_err_c;
      d_rvalid_q <= d_gnt_c;
      d_err_q    <= d_gnt_c & win_err_c;
    end
  end

  assign f_gnt   = f_gnt_c;
  assign d_gnt   = d_gnt_c;
  assign im_en   = im_en_c;
  assign im_addr = im_addr_c;

  // A flush drops the fetch response that lands in the redirect cycle
  assign f_rvalid = f_rvalid_q & ~f_flush;
  assign f_err    = f_err_q & ~f_flush;
  assign d_rvalid = d_rvalid_q;
  assign d_err    = d_err_q;

  // Data is zeroed unless a clean response is presented, so IM garbage never leaks out
  assign f_rdata = (f_rvalid & ~f_err) ? im_rdata : 32'h0;
  assign d_rdata = (d_rvalid & ~d_err) ? im_rdata : 32'h0;

`ifdef IM_ARB_STATS_EN
  logic [31:0] stat_f_q;
  logic [31:0] stat_d_q;
  logic [31:0] stat_stall_q;

  // Free-running wrap-around grant and fetch-stall counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_f_q     <= 32'h0;
      stat_d_q     <= 32'h0;
      stat_stall_q <= 32'h0;
    end else begin
      if (f_gnt_c)          stat_f_q     <= stat_f_q + 32'd1;
      if (d_gnt_c)          stat_d_q     <= stat_d_q + 32'd1;
      if (f_req & ~f_gnt_c) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_f_cnt     = stat_f_q;
  assign stat_d_cnt     = stat_d_q;
  assign stat_stall_cnt = stat_stall_q;
`else
  assign stat_f_cnt     = 32'h0;
  assign stat_d_cnt     = 32'h0;
  assign stat_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_im_access_arbiter.sv
// Directed bench for im_access_arbiter with a behavioural 1-cycle-latency IM model.
module tb_im_access_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = 32'h0;
  logic        f_flush = 1'b0;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        im_en;
  logic [11:0] im_addr;
  logic [31:0] im_rdata = 32'h0;
  logic [31:0] stat_f_cnt;
  logic [31:0] stat_d_cnt;
  logic [31:0] stat_stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_f    = 0;
  int exp_d    = 0;
  int exp_stall = 0;

  im_access_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .f_req         (f_req),
    .f_addr        (f_addr),
    .f_flush       (f_flush),
    .f_gnt         (f_gnt),
    .f_rvalid      (f_rvalid),
    .f_rdata       (f_rdata),
    .f_err         (f_err),
    .d_req         (d_req),
    .d_addr        (d_addr),
    .d_gnt         (d_gnt),
    .d_rvalid      (d_rvalid),
    .d_rdata       (d_rdata),
    .d_err         (d_err),
    .im_en         (im_en),
    .im_addr       (im_addr),
    .im_rdata      (im_rdata),
    .stat_f_cnt    (stat_f_cnt),
    .stat_d_cnt    (stat_d_cnt),
    .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [11:0] idx);
    return {16'hC0DE, 4'h0, idx};
  endfunction

  // Synchronous IM model: data for the enabled index appears after the edge
  always @(posedge clk) begin
    if (im_en) im_rdata <= rom(im_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One cycle: drive inputs after the edge, check the same-cycle grant outputs
  task automatic tick(input logic fr, input logic [31:0] fa, input logic dr,
                      input logic [31:0] da, input logic fl, input logic efg,
                      input logic edg, input logic een, input logic [11:0] eaddr);
    @(posedge clk);
    #1;
    f_req = fr; f_addr = fa; d_req = dr; d_addr = da; f_flush = fl;
    #2;
    check("f_gnt", 32'(f_gnt), 32'(efg));
    check("d_gnt", 32'(d_gnt), 32'(edg));
    check("im_en", 32'(im_en), 32'(een));
    check("im_addr", 32'(im_addr), 32'(eaddr));
    if (efg) exp_f++;
    if (edg) exp_d++;
    if (fr && !efg) exp_stall++;
  endtask

  task automatic idle();
    tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0);
  endtask

  task automatic check_stats(input string tag);
`ifdef IM_ARB_STATS_EN
    check({tag, "_stat_f"}, stat_f_cnt, 32'(exp_f));
    check({tag, "_stat_d"}, stat_d_cnt, 32'(exp_d));
    check({tag, "_stat_stall"}, stat_stall_cnt, 32'(exp_stall));
`else
    check({tag, "_stat_f"}, stat_f_cnt, 32'h0);
    check({tag, "_stat_d"}, stat_d_cnt, 32'h0);
    check({tag, "_stat_stall"}, stat_stall_cnt, 32'h0);
`endif
  endtask

  initial begin
    // Reset held: requests must be ignored and outputs quiet
    #1 reset = 1'b0;
    f_req = 1'b1; f_addr = 32'h3004; d_req = 1'b1; d_addr = 32'h3008;
    #10;
    check("rst_f_gnt", 32'(f_gnt), 32'h0);
    check("rst_d_gnt", 32'(d_gnt), 32'h0);
    check("rst_im_en", 32'(im_en), 32'h0);
    check("rst_im_addr", 32'(im_addr), 32'h0);
    check("rst_f_rvalid", 32'(f_rvalid), 32'h0);
    check("rst_f_rdata", f_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    f_req = 1'b0; d_req = 1'b0;
    #11 reset = 1'b1;

    // Plain fetch at 0x3004
    tick(1'b1, 32'h3004, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h001);
    check("s1_rvalid0", 32'(f_rvalid), 32'h0);
    tick(1'b1, 32'h3004, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h001);
    check("s1_rvalid1", 32'(f_rvalid), 32'h1);
    check("s1_rdata1", f_rdata, 32'hC0DE0001);
    check("s1_err1", 32'(f_err), 32'h0);
    check("s1_d_rvalid", 32'(d_rvalid), 32'h0);
    idle();
    check("s1_rvalid2", 32'(f_rvalid), 32'h1);
    check("s1_rdata2", f_rdata, 32'hC0DE0001);
    idle();
    check("s1_rvalid3", 32'(f_rvalid), 32'h0);
    check("s1_rdata3", f_rdata, 32'h0);

    // Starvation: debug waits four cycles behind continuous fetch, then wins once
    for (int t = 0; t < 4; t++) begin
      tick(1'b1, 32'h3000, 1'b1, 32'h3010, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
      if (t > 0) check("s2_f_rdata", f_rdata, 32'hC0DE0000);
    end
    tick(1'b1, 32'h3000, 1'b1, 32'h3010, 1'b0, 1'b0, 1'b1, 1'b1, 12'h004);
    check("s2_t4_f_rvalid", 32'(f_rvalid), 32'h1);
    check("s2_t4_d_rvalid", 32'(d_rvalid), 32'h0);
    tick(1'b1, 32'h3000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
    check("s2_t5_d_rvalid", 32'(d_rvalid), 32'h1);
    check("s2_t5_d_rdata", d_rdata, 32'hC0DE0004);
    check("s2_t5_d_err", 32'(d_err), 32'h0);
    check("s2_t5_f_rvalid", 32'(f_rvalid), 32'h0);
    check("s2_t5_f_rdata", f_rdata, 32'h0);
    check("s2_t5_starve", 32'(dut.starve_cnt), 32'h0);
    idle();
    check("s2_t6_f_rvalid", 32'(f_rvalid), 32'h1);
    check("s2_t6_d_rvalid", 32'(d_rvalid), 32'h0);
    check("s2_t6_d_rdata", d_rdata, 32'h0);
    check_stats("s2");

    // Address errors: misaligned, below base, one past the end
    tick(1'b1, 32'h3002, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    idle();
    check("e_mis_rvalid", 32'(f_rvalid), 32'h1);
    check("e_mis_err", 32'(f_err), 32'h1);
    check("e_mis_rdata", f_rdata, 32'h0);
    tick(1'b1, 32'h2FFC, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    idle();
    check("e_low_rvalid", 32'(f_rvalid), 32'h1);
    check("e_low_err", 32'(f_err), 32'h1);
    check("e_low_rdata", f_rdata, 32'h0);
    tick(1'b1, 32'h7000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    idle();
    check("e_high_rvalid", 32'(f_rvalid), 32'h1);
    check("e_high_err", 32'(f_err), 32'h1);
    check("e_high_rdata", f_rdata, 32'h0);
    // Last valid word
    tick(1'b1, 32'h6FFC, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 12'hFFF);
    idle();
    check("e_last_err", 32'(f_err), 32'h0);
    check("e_last_rdata", f_rdata, 32'hC0DE0FFF);
    // Debug misaligned access
    tick(1'b0, 32'h0, 1'b1, 32'h3001, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    idle();
    check("e_dbg_rvalid", 32'(d_rvalid), 32'h1);
    check("e_dbg_err", 32'(d_err), 32'h1);
    check("e_dbg_rdata", d_rdata, 32'h0);

    // Flush drops the response in the redirect cycle but not the new grant
    tick(1'b1, 32'h3000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
    tick(1'b1, 32'h3008, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h002);
    check("fl_rvalid", 32'(f_rvalid), 32'h0);
    check("fl_err", 32'(f_err), 32'h0);
    check("fl_rdata", f_rdata, 32'h0);
    idle();
    check("fl_next_rvalid", 32'(f_rvalid), 32'h1);
    check("fl_next_rdata", f_rdata, 32'hC0DE0002);
    check_stats("pre_rst");

    // Asynchronous reset in the middle of a live response cycle
    tick(1'b1, 32'h3004, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h001);
    tick(1'b1, 32'h3008, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h002);
    check("ar_pre_rvalid", 32'(f_rvalid), 32'h1);
    #2 reset = 1'b0;
    exp_f = 0; exp_d = 0; exp_stall = 0;
    #1;
    check("ar_rvalid", 32'(f_rvalid), 32'h0);
    check("ar_rdata", f_rdata, 32'h0);
    check("ar_f_gnt", 32'(f_gnt), 32'h0);
    check("ar_im_en", 32'(im_en), 32'h0);
    @(posedge clk);
    #1;
    check("ar_edge_rvalid", 32'(f_rvalid), 32'h0);
    f_req = 1'b0;
    #3 reset = 1'b1;
    idle();
    check("ar_post_rvalid", 32'(f_rvalid), 32'h0);
    tick(1'b1, 32'h3004, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h001);
    check("ar_s1_rvalid0", 32'(f_rvalid), 32'h0);
    idle();
    check("ar_s1_rvalid1", 32'(f_rvalid), 32'h1);
    check("ar_s1_rdata", f_rdata, 32'hC0DE0001);
    check_stats("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
